// File: rtl/hd_sample_encoder_if.sv
// rtl/hd_sample_encoder_if.sv - symbol-stream and sample-result signal bundle for hd_sample_encoder
interface hd_sample_encoder_if #(
    parameter int N     = 1024,
    parameter int CNT_W = 8
);
    logic [4:0]       inputLetter;
    logic [4:0]       position;
    logic [4:0]       label;
    logic             t_signal;
    logic             f_signal;
    logic             tf_signal;
    logic [N-1:0]     hv_out;
    logic [4:0]       out_label;
    logic [CNT_W-1:0] out_count;
    logic             out_label_err;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output inputLetter, position, label, t_signal, f_signal, out_ready,
        input  tf_signal, hv_out, out_label, out_count, out_label_err, out_valid
    );

    modport slave (
        input  inputLetter, position, label, t_signal, f_signal, out_ready,
        output tf_signal, hv_out, out_label, out_count, out_label_err, out_valid
    );
endinterface

// File: rtl/hd_sample_encoder.sv
// rtl/hd_sample_encoder.sv - binds symbols to position vectors, bundles them and thresholds into a sample hypervector
module hd_sample_encoder #(
    parameter int N     = 1024,
    parameter int CHUNK = 64,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    hd_sample_encoder_if.slave  bus
);
    localparam int NCH = N / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int AW  = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, ACCUM, THRESH, OUT} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    chunk_q;
    logic             last_chunk;
    logic             accept_sym;

    logic [4:0]       sym_l_q;
    logic [4:0]       sym_p_q;
    logic [4:0]       sample_label_q;
    logic             first_seen_q;
    logic             err_q;
    logic [CNT_W-1:0] nsym_q;
    logic [CNT_W-1:0] cnt_q [N];

    logic [N-1:0]     hv_q;
    logic [4:0]       out_label_q;
    logic [CNT_W-1:0] out_count_q;
    logic             out_err_q;

    logic [31:0]      off_a;
    logic [31:0]      off_b;
    logic [AW-1:0]    lane_idx [CHUNK];
    logic [CHUNK-1:0] enc_chunk;

    // Base vector bit: bit 16 of the golden-ratio hash of the index.
    function automatic logic base_bit(input logic [31:0] idx);
        logic [31:0] prod;
        prod = idx * 32'h9E3779B1;
        return prod[16];
    endfunction

    function automatic logic [31:0] wrap_n(input logic [31:0] a);
        return (a >= 32'(N)) ? a - 32'(N) : a;
    endfunction

    assign last_chunk = (chunk_q == CW'(NCH - 1));
    assign accept_sym = (state_q == IDLE) && bus.t_signal;

    always_comb begin
        off_a = (32'd37 * 32'(sym_l_q)) % 32'(N);
        off_b = (32'(N / 2) + 32'd13 * 32'(sym_p_q)) % 32'(N);
    end

    // Both offsets are already reduced mod N, so one conditional subtract wraps each lane.
    always_comb begin
        enc_chunk = '0;
        for (int k = 0; k < CHUNK; k++) begin
            lane_idx[k]  = AW'(32'(chunk_q) * 32'(CHUNK) + 32'(k));
            enc_chunk[k] = base_bit(wrap_n(32'(lane_idx[k]) + off_a))
                         ^ base_bit(wrap_n(32'(lane_idx[k]) + off_b));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A symbol takes priority over end-of-sample; the sender keeps f_signal up until it lands.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.t_signal) begin
                    state_d = ACCUM;
                end else if (bus.f_signal) begin
                    state_d = THRESH;
                end
            end
            ACCUM: begin
                if (last_chunk) begin
                    state_d = IDLE;
                end
            end
            THRESH: begin
                if (last_chunk) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chunk_q        <= '0;
            sym_l_q        <= '0;
            sym_p_q        <= '0;
            sample_label_q <= '0;
            first_seen_q   <= 1'b0;
            err_q          <= 1'b0;
            nsym_q         <= '0;
            hv_q           <= '0;
            out_label_q    <= '0;
            out_count_q    <= '0;
            out_err_q      <= 1'b0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            if (accept_sym) begin
                sym_l_q <= bus.inputLetter;
                sym_p_q <= bus.position;
                if (!first_seen_q) begin
                    sample_label_q <= bus.label;
                    first_seen_q   <= 1'b1;
                end else if (bus.label != sample_label_q) begin
                    err_q <= 1'b1;
                end
                if (nsym_q != '1) begin
                    nsym_q <= nsym_q + CNT_W'(1);
                end
            end

            if (state_q == ACCUM || state_q == THRESH) begin
                chunk_q <= last_chunk ? '0 : chunk_q + CW'(1);
            end

            if (state_q == ACCUM) begin
                for (int k = 0; k < CHUNK; k++) begin
                    if (enc_chunk[k] && cnt_q[lane_idx[k]] != '1) begin
                        cnt_q[lane_idx[k]] <= cnt_q[lane_idx[k]] + CNT_W'(1);
                    end
                end
            end

            // Strict majority: 2*cnt > nsym, so ties and empty samples give 0.
            if (state_q == THRESH) begin
                for (int k = 0; k < CHUNK; k++) begin
                    hv_q[lane_idx[k]]  <= ({cnt_q[lane_idx[k]], 1'b0} > {1'b0, nsym_q});
                    cnt_q[lane_idx[k]] <= '0;
                end
                if (last_chunk) begin
                    out_label_q  <= sample_label_q;
                    out_count_q  <= nsym_q;
                    out_err_q    <= err_q;
                    nsym_q       <= '0;
                    first_seen_q <= 1'b0;
                    err_q        <= 1'b0;
                end
            end
        end
    end

    assign bus.tf_signal     = (state_q == IDLE) && !rst;
    assign bus.out_valid     = (state_q == OUT);
    assign bus.hv_out        = hv_q;
    assign bus.out_label     = out_label_q;
    assign bus.out_count     = out_count_q;
    assign bus.out_label_err = out_err_q;
endmodule

// File: doc/hd_sample_encoder.md
# hd_sample_encoder

Hardware consumer of the test-sample symbol stream: accepts digit symbols (`inputLetter`, `position`, `label`) under the `t_signal`/`tf_signal` handshake. It binds each symbol's item hypervector with a position hypervector and bundles the results into per-dimension counters. On end-of-sample it thresholds the counters into one N-bit sample hypervector with its label, ready for the associative-memory search stage.

## Interface
- `N`, 1024: hypervector dimension; multiple of `CHUNK`.
- `CHUNK`, 64: dimensions processed per cycle.
- `CNT_W`, 8: width of the per-dimension counters and of the symbol count; both saturate at 2^CNT_W−1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `inputLetter` in 5: symbol value L (0..31 encoded; stream uses 0..9).
- `position` in 5: symbol position P within the sample.
- `label` in 5: class label of the current sample.
- `t_signal` in 1: symbol valid.
- `f_signal` in 1: end-of-sample request.
- `tf_signal` out 1: ready; high only in IDLE while `rst` is low.
- `hv_out` out N: sample hypervector; reset 0.
- `out_label` out 5: label of the emitted sample; reset 0.
- `out_count` out CNT_W: symbols bundled (saturated); reset 0.
- `out_label_err` out 1: a symbol in the sample carried a label different from the first symbol's label; reset 0.
- `out_valid` out 1: result valid; reset 0.
- `out_ready` in 1: downstream accepts result.

## Operation
- Base vector: base[i] = bit 16 of (i × 32'h9E3779B1) mod 2^32, for i in 0..N−1. It is fixed and generated combinationally from the index.
- Encoded symbol: enc[i] = base[(i + 37·L) mod N] XOR base[(i + N/2 + 13·P) mod N].
- States:
  - IDLE: `tf_signal` = 1.
  - ACCUM: processes N/CHUNK chunks.
  - THRESH: processes N/CHUNK chunks.
  - OUT.
- IDLE, `t_signal` = 1: the symbol is accepted, and L, P and the label are registered.
  - On the first symbol of a sample, the label is latched into the sample label.
  - On any later symbol, a label mismatch sets a sticky error bit.
  - The symbol count increments (saturating). Next state is ACCUM.
- IDLE, `f_signal` = 1 and `t_signal` = 0: next state is THRESH.
- IDLE, both `t_signal` and `f_signal` high: the symbol is accepted and `f_signal` is ignored. The sender holds `f_signal` until it is accepted.
- ACCUM chunk j: for every i in [j·CHUNK, (j+1)·CHUNK), cnt[i] increments (saturating) when enc[i] = 1. After the last chunk, the state returns to IDLE.
- THRESH chunk j: hv_out[i] = 1 iff 2·cnt[i] > nsym. A tie or nsym = 0 gives 0. In the same cycle, cnt[i] for the chunk is cleared. After the last chunk:
  - `out_label`, `out_count` and `out_label_err` load from the sample registers.
  - nsym, the first-symbol flag and the error bit clear.
  - Next state is OUT.
- OUT: `out_valid` = 1 and the outputs are stable. When `out_ready` = 1 at an edge, next state is IDLE and `out_valid` drops. `hv_out` holds its value until the next THRESH.
- Reset in any state:
  - state goes to IDLE;
  - all counters, nsym and the flags clear;
  - all outputs return to their reset values;
  - any in-flight symbol or sample is discarded.

## Timing
- Symbol accepted at edge E0. ACCUM updates chunk j at edge E(j+1). The state is IDLE after edge E(N/CHUNK).
- `tf_signal` is low during E1..E(N/CHUNK), so the minimum symbol spacing is N/CHUNK+1 cycles (17 with defaults).
- `f_signal` accepted at E0: THRESH runs through E1..E(N/CHUNK). `out_valid` rises after edge E(N/CHUNK).
- End-of-sample to `out_valid` is N/CHUNK cycles. `out_ready` may already be high, giving a single-cycle `out_valid` pulse.
- `tf_signal` is low in ACCUM, THRESH and OUT. It is forced low while `rst` is high and rises combinationally when `rst` falls.

## Test plan
- Reset: assert `rst` mid-ACCUM, then release.
  - `tf_signal` = 0 during reset and 1 after release.
  - `out_valid` = 0, `hv_out` = 0.
  - A following empty sample (`f_signal` only) yields `hv_out` = 0 and `out_count` = 0.
- Single symbol: L=3, P=0, label=7, then `f_signal`.
  - `hv_out` equals enc(3,0) bit-exact against the reference model.
  - `out_count` = 1, `out_label` = 7, `out_label_err` = 0.
  - `tf_signal` is low for exactly 16 cycles after each acceptance.
- Majority: three symbols, (L=1,P=0), (L=1,P=1), (L=2,P=2), label 4.
  - hv_out[i] = 1 exactly where at least 2 of the 3 encodings are 1.
  - `out_count` = 3.
- Tie and label error: two symbols with labels 5 then 6.
  - Tie dimensions give 0.
  - `out_label` = 5, `out_label_err` = 1.
  - The next sample reports `out_label_err` = 0.
- Backpressure: hold `out_ready` = 0 for 10 cycles.
  - `out_valid` and the outputs stay stable and `tf_signal` stays 0.
  - `out_ready` = 1 returns the block to IDLE on the next edge.
- Simultaneous `t_signal` + `f_signal` in IDLE: the symbol is bundled and the sample is not closed. `f_signal` held high closes the sample after ACCUM, with `out_count` including that symbol.
